// File: rtl/tx_egress_arbiter_if.sv
// Bundle between the transaction-layer output FIFOs, the egress arbiter and the
// downstream consumer / counter reader. The arbiter takes the master view.
interface tx_egress_arbiter_if;
  logic        emptyP0, emptyP1, emptyP2, emptyP3;
  logic [11:0] dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3;
  logic        popOutP0, popOutP1, popOutP2, popOutP3;
  logic        ready;
  logic [11:0] dataOut;
  logic        validOut;
  logic [1:0]  grant;
  logic        init;
  logic        req;
  logic [1:0]  idx;
  logic [4:0]  counterOut;
  logic        counterValid;

  modport master (
    input  emptyP0, emptyP1, emptyP2, emptyP3,
    input  dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3,
    input  ready, init, req, idx,
    output popOutP0, popOutP1, popOutP2, popOutP3,
    output dataOut, validOut, grant, counterOut, counterValid
  );

  modport slave (
    output emptyP0, emptyP1, emptyP2, emptyP3,
    output dataOutputP0, dataOutputP1, dataOutputP2, dataOutputP3,
    output ready, init, req, idx,
    input  popOutP0, popOutP1, popOutP2, popOutP3,
    input  dataOut, validOut, grant, counterOut, counterValid
  );
endinterface

// File: rtl/tx_egress_arbiter.sv
// Round-robin egress arbiter: drains four FIFOs one word at a time onto a
// registered valid/ready output and keeps a 5-bit forwarded-word count per port.
module tx_egress_arbiter (
  input  logic                clk,
  input  logic                reset,
  tx_egress_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, WAIT = 2'd2} state_t;

  state_t      state, state_nx;
  logic [1:0]  sel, sel_nx, last;
  logic [3:0]  pop_q, pop_nx;
  logic [11:0] data_q;
  logic        valid_q;
  logic [1:0]  grant_q;
  logic [4:0]  count [4];
  logic [4:0]  cnt_out_q;
  logic        cnt_valid_q;

  logic [3:0]  empty;
  logic [11:0] fifo_data [4];
  logic        slot_free, load, rr_found;
  logic [1:0]  rr_pick, rr_cand;

  assign empty        = {bus.emptyP3, bus.emptyP2, bus.emptyP1, bus.emptyP0};
  assign fifo_data[0] = bus.dataOutputP0;
  assign fifo_data[1] = bus.dataOutputP1;
  assign fifo_data[2] = bus.dataOutputP2;
  assign fifo_data[3] = bus.dataOutputP3;

  // The slot counts as free when the word on it is being taken on this edge.
  assign slot_free = !valid_q || bus.ready;
  assign load      = (state == WAIT);

  // Search starts one past the last served port, so a backlogged port waits at most three grants.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    rr_found = 1'b0;
    rr_pick  = last;
    rr_cand  = last;
    for (int i = 1; i <= 4; i++) begin
      rr_cand = last + 2'(i);
      if (!rr_found && !empty[rr_cand]) begin
        rr_found = 1'b1;
        rr_pick  = rr_cand;
      end
    end
  end

  always_comb begin
    state_nx = state;
    sel_nx   = sel;
    pop_nx   = '0;
    unique case (state)
      IDLE: if (rr_found && slot_free) begin
        state_nx = POP;
        sel_nx   = rr_pick;
        pop_nx   = 4'b0001 << rr_pick;
      end
      POP:     state_nx = WAIT;
      WAIT:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      sel     <= '0;
      last    <= 2'd3;
      pop_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      sel   <= sel_nx;
      pop_q <= pop_nx;
      if (load) begin
        data_q  <= fifo_data[sel];
        grant_q <= sel;
        valid_q <= 1'b1;
        last    <= sel;
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counter array is cleared by the async reset like any other register, so it stays flops.
      for (int i = 0; i < 4; i++) count[i] <= '0;
      cnt_out_q   <= '0;
      cnt_valid_q <= 1'b0;
    end else begin
      if (bus.req) begin
        cnt_out_q   <= count[bus.idx];
        cnt_valid_q <= 1'b1;
      end else begin
        cnt_valid_q <= 1'b0;
      end
      if (bus.init) begin
        for (int i = 0; i < 4; i++) count[i] <= '0;
      end else if (load) begin
        count[sel] <= count[sel] + 5'd1;
      end
    end
  end

  assign bus.popOutP0     = pop_q[0];
  assign bus.popOutP1     = pop_q[1];
  assign bus.popOutP2     = pop_q[2];
  assign bus.popOutP3     = pop_q[3];
  assign bus.dataOut      = data_q;
  assign bus.validOut     = valid_q;
  assign bus.grant        = grant_q;
  assign bus.counterOut   = cnt_out_q;
  assign bus.counterValid = cnt_valid_q;
endmodule

// File: tb/tb_tx_egress_arbiter.sv
// Bench for tx_egress_arbiter: FIFO models feed the DUT, a word-level round-robin
// model predicts every forwarded word and counter read.
module tb_tx_egress_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  tx_egress_arbiter_if bus ();
  tx_egress_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          port;
    logic [11:0] word;
    int          exp_grant;
    int          exp_count;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] fq [4][$];
  logic [11:0] mq [4][$];
  logic [11:0] fdata [4];
  int          m_last = 3;
  int          m_count [4];
  int          glog [$];
  int          pops = 0;
  int          words = 0;
  logic [3:0]  pop_s = '0;
  logic        prev_v = 1'b0;
  logic        prev_rdy = 1'b0;
  logic [11:0] prev_data;
  logic [1:0]  prev_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    for (int i = 1; i <= 4; i++) begin
      if (mq[(m_last + i) % 4].size() > 0) return (m_last + i) % 4;
    end
    return -1;
  endfunction

  function automatic bit model_empty();
    return mq[0].size() == 0 && mq[1].size() == 0 && mq[2].size() == 0 && mq[3].size() == 0;
  endfunction

  // FIFO side: a pop seen in cycle T updates the head data just after the edge ending T.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      for (int n = 0; n < 4; n++) fq[n].delete();
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (pop_s[n]) begin
          if (fq[n].size() == 0) check("pop_of_empty_fifo", 1, 0);
          else fdata[n] = fq[n].pop_front();
        end
      end
    end
    bus.emptyP0 = (fq[0].size() == 0);
    bus.emptyP1 = (fq[1].size() == 0);
    bus.emptyP2 = (fq[2].size() == 0);
    bus.emptyP3 = (fq[3].size() == 0);
    bus.dataOutputP0 = fdata[0];
    bus.dataOutputP1 = fdata[1];
    bus.dataOutputP2 = fdata[2];
    bus.dataOutputP3 = fdata[3];
  end

  // Output monitor and reference model, sampled mid-cycle.
  always @(negedge clk) begin
    int          p;
    logic [11:0] w;
    if (!reset) begin
      prev_v = 1'b0;
      prev_rdy = 1'b0;
      pop_s = '0;
      m_last = 3;
      for (int k = 0; k < 4; k++) begin
        m_count[k] = 0;
        mq[k].delete();
      end
    end else begin
      pop_s = {bus.popOutP3, bus.popOutP2, bus.popOutP1, bus.popOutP0};
      if (pop_s != 4'b0) begin
        pops++;
        check("pop_onehot", 32'($countones(pop_s)), 1);
      end
      if (bus.init) for (int k = 0; k < 4; k++) m_count[k] = 0;
      if (bus.validOut && !prev_v) begin
        words++;
        glog.push_back(int'(bus.grant));
        p = pick();
        if (p < 0) begin
          check("spurious_word", 1, 0);
        end else begin
          w = mq[p].pop_front();
          check("word_grant", bus.grant, p);
          check("word_data", bus.dataOut, w);
          if (!bus.init) m_count[p] = (m_count[p] + 1) % 32;
          m_last = p;
        end
      end else if (bus.validOut && prev_v) begin
        check("valid_drop_after_accept", prev_rdy, 0);
        check("hold_data", bus.dataOut, prev_data);
        check("hold_grant", bus.grant, prev_grant);
      end
      prev_v = bus.validOut;
      prev_rdy = bus.ready;
      prev_data = bus.dataOut;
      prev_grant = bus.grant;
    end
  end

  task automatic push(input int p, input logic [11:0] w);
    fq[p].push_back(w);
    mq[p].push_back(w);
  endtask

  task automatic wait_word(input int budget);
    int start;
    bit ok;
    start = words;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (words != start) begin ok = 1; break; end
    end
    check("wait_word_timeout", ok, 1);
  endtask

  task automatic wait_pop(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if ({bus.popOutP3, bus.popOutP2, bus.popOutP1, bus.popOutP0} != 4'b0) begin ok = 1; break; end
    end
    check("wait_pop_timeout", ok, 1);
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    bus.ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk); #1;
      if (model_empty() && !bus.validOut) begin ok = 1; break; end
    end
    check("drain_timeout", ok, 1);
  endtask

  task automatic read_cnt(input int i, output logic [4:0] got);
    logic [4:0] exp;
    @(negedge clk); #1;
    bus.req = 1'b1;
    bus.idx = 2'(i);
    exp = 5'(m_count[i]);
    @(negedge clk); #1;
    bus.req = 1'b0;
    check("cnt_read_valid", bus.counterValid, 1);
    check("cnt_read_value", bus.counterOut, exp);
    got = bus.counterOut;
    @(negedge clk); #1;
    check("cnt_valid_clear", bus.counterValid, 0);
    check("cnt_hold", bus.counterOut, exp);
  endtask

  task automatic reset_dut();
    @(negedge clk); #2;
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl [6];
    logic [4:0] got;
    int         p0, w0, n;
    bit         done;

    tbl[0] = '{port: 2, word: 12'hA5C, exp_grant: 2, exp_count: 1};
    tbl[1] = '{port: 0, word: 12'h123, exp_grant: 0, exp_count: 1};
    tbl[2] = '{port: 2, word: 12'hFFF, exp_grant: 2, exp_count: 2};
    tbl[3] = '{port: 3, word: 12'h000, exp_grant: 3, exp_count: 1};
    tbl[4] = '{port: 1, word: 12'h7A1, exp_grant: 1, exp_count: 1};
    tbl[5] = '{port: 1, word: 12'h055, exp_grant: 1, exp_count: 2};

    bus.ready = 1'b0;
    bus.req = 1'b0;
    bus.idx = 2'd0;
    bus.init = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_pop", {bus.popOutP3, bus.popOutP2, bus.popOutP1, bus.popOutP0}, 0);
    check("rst_data", bus.dataOut, 0);
    check("rst_valid", bus.validOut, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_cnt_out", bus.counterOut, 0);
    check("rst_cnt_valid", bus.counterValid, 0);
    @(posedge clk); #3;
    reset = 1'b1;

    // Single-word vectors, starting from the reset pointer.
    @(posedge clk); #1;
    bus.ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      p0 = pops;
      push(tbl[v].port, tbl[v].word);
      wait_word(20);
      check("tbl_grant", bus.grant, tbl[v].exp_grant);
      check("tbl_data", bus.dataOut, tbl[v].word);
      check("tbl_pop_count", pops - p0, 1);
      @(negedge clk); #1;
      check("tbl_valid_one_cycle", bus.validOut, 0);
      read_cnt(tbl[v].port, got);
      check("tbl_count", got, tbl[v].exp_count);
    end

    // Round-robin over four backlogged ports.
    reset_dut();
    glog.delete();
    w0 = words;
    p0 = pops;
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 2; k++) push(p, 12'(256 + p * 16 + k));
    drain(100);
    check("rr_words", words - w0, 8);
    check("rr_pops", pops - p0, 8);
    check("rr_log_size", glog.size(), 8);
    if (glog.size() == 8)
      for (int k = 0; k < 8; k++) check("rr_order", glog[k], k % 4);

    // Backpressure: one word sits on the slot, no further pop until it is taken.
    @(posedge clk); #1;
    bus.ready = 1'b0;
    p0 = pops;
    push(1, 12'h311);
    push(1, 12'h322);
    push(1, 12'h333);
    wait_word(20);
    repeat (8) begin @(negedge clk); #1; end
    check("bp_single_pop", pops - p0, 1);
    check("bp_valid_held", bus.validOut, 1);
    check("bp_data_held", bus.dataOut, 12'h311);
    @(posedge clk); #1;
    bus.ready = 1'b1;
    @(posedge clk); #1;
    bus.ready = 1'b0;
    @(negedge clk); #1;
    check("bp_valid_dropped", bus.validOut, 0);
    repeat (10) begin @(negedge clk); #1; end
    check("bp_second_pop", pops - p0, 2);
    check("bp_second_valid", bus.validOut, 1);
    check("bp_second_data", bus.dataOut, 12'h322);
    drain(50);

    // Counter wrap, then a read on the same edge as an increment.
    reset_dut();
    for (int k = 0; k < 33; k++) push(3, 12'(k * 7 + 1));
    drain(300);
    read_cnt(3, got);
    check("wrap_count", got, 1);
    push(3, 12'hABC);
    wait_pop(20);
    @(negedge clk); #1;
    bus.req = 1'b1;
    bus.idx = 2'd3;
    @(negedge clk); #1;
    bus.req = 1'b0;
    check("same_edge_old_value", bus.counterOut, 1);
    check("same_edge_cnt_valid", bus.counterValid, 1);
    check("same_edge_loaded", bus.validOut, 1);
    read_cnt(3, got);
    check("same_edge_after", got, 2);
    drain(30);

    // init clears counters while forwarding carries on.
    reset_dut();
    for (int k = 0; k < 5; k++) push(0, 12'(512 + k));
    drain(60);
    read_cnt(0, got);
    check("init_pre_count", got, 5);
    for (int k = 0; k < 6; k++) push(1, 12'(1024 + k));
    wait_pop(20);
    bus.init = 1'b1;
    bus.req = 1'b1;
    bus.idx = 2'd0;
    @(negedge clk); #1;
    bus.init = 1'b0;
    bus.req = 1'b0;
    check("init_read_old", bus.counterOut, 5);
    read_cnt(0, got);
    check("init_cleared", got, 0);
    drain(60);
    read_cnt(1, got);
    check("init_p1_count", got, 6);

    // Async reset while a popped word is in flight.
    push(2, 12'h5A5);
    wait_pop(20);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("areset_pop", {bus.popOutP3, bus.popOutP2, bus.popOutP1, bus.popOutP0}, 0);
    check("areset_valid", bus.validOut, 0);
    check("areset_data", bus.dataOut, 0);
    check("areset_grant", bus.grant, 0);
    check("areset_cnt_out", bus.counterOut, 0);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    read_cnt(1, got);
    check("areset_counter_cleared", got, 0);
    push(3, 12'h0F0);
    wait_pop(20);
    reset = 1'b0;
    #1;
    check("areset_pop_drop", {bus.popOutP3, bus.popOutP2, bus.popOutP1, bus.popOutP0}, 0);
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    glog.delete();
    for (int p = 0; p < 4; p++) push(p, 12'(2048 + p));
    drain(60);
    check("restart_log_size", glog.size(), 4);
    if (glog.size() > 0) check("restart_p0_first", glog[0], 0);

    // Randomized backlogs with random backpressure and counter reads.
    reset_dut();
    for (int r = 0; r < 6; r++) begin
      for (int p = 0; p < 4; p++) begin
        n = $urandom_range(0, 6);
        for (int k = 0; k < n; k++) push(p, 12'($urandom));
      end
      done = 0;
      for (int c = 0; c < 600; c++) begin
        @(posedge clk); #1;
        bus.ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) read_cnt(int'($urandom_range(0, 3)), got);
        if (model_empty() && !bus.validOut) begin done = 1; break; end
      end
      check("random_drain", done, 1);
      for (int p = 0; p < 4; p++) read_cnt(p, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tx_egress_arbiter.md
# tx_egress_arbiter

Downstream consumer of the transaction-layer block's four output FIFOs (P0..P3). It watches each port's empty flag and pops one 12-bit word at a time, using round-robin among non-empty ports. Each popped word is presented on a single registered output with a valid/ready handshake. Per-port 5-bit forwarded-word counters are readable with the same req/idx/valid style the transaction layer uses for its own counter.

## Interface
- No parameters; widths fixed: data 12 bits, counters 5 bits, 4 ports.
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- init  in  1  synchronous; 1 clears all four counters
- emptyP0..emptyP3  in  1 each  FIFO empty flag from the transaction layer, port n
- dataOutputP0..dataOutputP3  in  12 each  FIFO read data, port n; valid the cycle after popOutPn
- ready  in  1  downstream accepts dataOut on an edge where validOut=1 and ready=1
- req  in  1  counter read request
- idx  in  2  counter read select (port 0..3)
- popOutP0..popOutP3  out  1 each  pop strobe to FIFO n; at most one high per cycle
- dataOut  out  12  forwarded word
- validOut  out  1  dataOut holds an unconsumed word
- grant  out  2  port number of the word in dataOut
- counterOut  out  5  counter value returned for idx
- counterValid  out  1  counterOut is valid

## Operation
- Reset values (reset=0): state=IDLE, all popOutPn=0, dataOut=0, validOut=0, grant=0, counterOut=0, counterValid=0, all counters=0, last=3.
- FSM states: IDLE, POP, WAIT. All outputs are driven from registers; no combinational path runs from inputs to outputs.
- IDLE → POP when both hold:
  - at least one emptyPn=0;
  - the output slot is free: validOut=0, or (validOut=1 and ready=1) on this edge.
  - On this transition, sel is registered as the first non-empty port searching last+1, last+2, ... mod 4. Otherwise stay in IDLE.
- POP: popOutP[sel]=1 for exactly this one cycle. Next state is WAIT.
- WAIT: dataOutputP[sel] is valid. On the edge ending WAIT:
  - dataOut ← dataOutputP[sel]; grant ← sel; validOut ← 1; last ← sel;
  - count[sel] ← count[sel]+1 (wraps from 31 to 0);
  - next state is IDLE.
- Handshake: when validOut=1 and ready=1 on an edge with no new load, validOut ← 0. dataOut and grant hold their last value.
- validOut must never be set over an unconsumed word. The IDLE slot-free check guarantees this.
- Throughput: at most one word per 3 cycles. A port with a continuous backlog is served at least once every 4 grants.
- emptyPn is sampled only in IDLE. Only this block pops, so a port found non-empty stays non-empty through POP.
- Counter read: if req=1, then on the next edge counterOut ← count[idx] and counterValid ← 1. If req=0, counterValid ← 0 and counterOut holds.
- Same-edge read and increment of the same counter: the read returns the pre-increment value.
- init=1: all counters ← 0 on the edge. init has priority over an increment on the same edge. The FSM, data path, and last are unaffected. A read in the same cycle returns the pre-clear value.
- Reset mid-operation: all state returns to reset values at once and popOutPn drops without waiting for a clock edge. A word popped but not yet captured is lost.

## Timing
- Pop to capture: popOutPn is high in cycle T. The transaction layer updates dataOutputPn at the edge ending T. The block captures it at the edge ending T+1, and validOut=1 from cycle T+2.
- Minimum latency from a port going non-empty (sampled in IDLE) to validOut=1 is 3 edges.
- The counter read response arrives 1 cycle after req.

## Test plan
- Reset then single word: emptyP2=0 with FIFO head 0xA5C, ready=1. Expect popOutP2 for 1 cycle, dataOut=0xA5C, grant=2, validOut for 1 cycle, count[2]=1.
- Round-robin: all four FIFOs hold 2 words, ready=1. Expect grant order 0,1,2,3,0,1,2,3, popOutPn one-hot, 8 words total with no duplicate or skip.
- Backpressure: ready=0 with 3 words in P1. Expect exactly one pop, after which validOut=1 and dataOut holds stable. Then ready=1 for 1 cycle: validOut drops or reloads, and no second pop occurs until the slot is free.
- Counter wrap and read: forward 33 words from P3, then req=1 with idx=3. Expect counterOut=1 and counterValid=1 one cycle later. The same-edge increment/read case returns the old value.
- init: with count[0]=5, pulse init together with req and idx=0. Expect the read to return 5 and a subsequent read to return 0. The FSM continues forwarding unaffected.
- Async reset in WAIT: drive reset=0 between edges. Expect popOutPn, validOut, and counters to go to 0 before the next edge. After release, operation restarts with P0 priority.
